// File: rtl/dffram_wb_ctrl.sv
// dffram_wb_ctrl: Wishbone classic slave that drives one 256x32 single-port DFFRAM macro
//   mclk, reset_n                      clock (also clocks the RAM), async active-low reset
//   wbd_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i  Wishbone request; adr_i[1:0] ignored
//   wbd_dat_o, wbd_ack_o               registered read data, one-cycle acknowledge
//   ram_en_o/we_o/a_o/di_o, ram_do_i   RAM pins (Do valid one cycle after an EN edge)
//   clr_done_o                         RAM ready for bus access
//   Define DFFRAM_CLR_EN to zero-fill CLR_WORDS words after every reset before serving the bus.
module dffram_wb_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int CLR_WORDS = 256
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              wbd_cyc_i,
    input  logic              wbd_stb_i,
    input  logic              wbd_we_i,
    input  logic [ADDR_W+1:0] wbd_adr_i,
    input  logic [3:0]        wbd_sel_i,
    input  logic [31:0]       wbd_dat_i,
    output logic [31:0]       wbd_dat_o,
    output logic              wbd_ack_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [31:0]       ram_di_o,
    input  logic [31:0]       ram_do_i,
    output logic              clr_done_o
);
`ifdef DFFRAM_CLR_EN
    typedef enum logic [1:0] {CLR, IDLE, RD_WAIT, ACK} state_t;
    localparam state_t RST_STATE = CLR;
`else
    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
    localparam state_t RST_STATE = IDLE;
`endif
    state_t state, state_nx;
    logic   req;
    logic   unused_bits;
    // RAM pins are combinational, so gate with reset to force them idle the moment reset asserts
    assign req         = wbd_cyc_i & wbd_stb_i & reset_n;
    assign wbd_ack_o   = state == ACK;
    assign unused_bits = ^{wbd_adr_i[1:0], CLR_WORDS[0]};
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RST_STATE;
            wbd_dat_o <= '0;
        end else begin
            state <= state_nx;
            if (state == RD_WAIT && wbd_cyc_i) wbd_dat_o <= ram_do_i;
        end
    end
`ifdef DFFRAM_CLR_EN
    logic [ADDR_W-1:0] cnt;
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= (state == CLR && state_nx == CLR) ? cnt + 1'b1 : '0;
    end
    assign clr_done_o = state != CLR;
`else
    assign clr_done_o = 1'b1;
`endif
    always_comb begin
        state_nx = state;
        ram_en_o = 1'b0;
        ram_we_o = 4'h0;
        ram_a_o  = '0;
        ram_di_o = '0;
        case (state)
`ifdef DFFRAM_CLR_EN
            CLR: begin
                ram_en_o = reset_n;
                ram_we_o = {4{reset_n}};
                ram_a_o  = reset_n ? cnt : '0;
                state_nx = (cnt == ADDR_W'(CLR_WORDS - 1)) ? IDLE : CLR;
            end
`endif
            IDLE: if (req) begin
                ram_en_o = 1'b1;
                ram_we_o = wbd_we_i ? wbd_sel_i : 4'h0;
                ram_a_o  = wbd_adr_i[ADDR_W+1:2];
                ram_di_o = wbd_dat_i;
                state_nx = wbd_we_i ? ACK : RD_WAIT;
            end
            RD_WAIT: state_nx = wbd_cyc_i ? ACK : IDLE;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dffram_wb_ctrl.sv
// tb_dffram_wb_ctrl: directed and random bus traffic against a RAM model and a word-level reference memory
module tb_dffram_wb_ctrl;
    localparam int AW = 8;
    logic          mclk = 1'b0, reset_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [AW+1:0] adr = '0;
    logic [3:0]    sel = '0;
    logic [31:0]   dat_i = '0;
    logic [31:0]   dat_o, ram_di, ram_do;
    logic          ack, ram_en, clr_done;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   mem [256];
    logic [31:0]   ref_mem [256];
    logic [31:0]   last_rd = '0;
    logic          preload = 1'b1;
    int            checks = 0, errors = 0;

    always #5 mclk = ~mclk;

    dffram_wb_ctrl #(.ADDR_W(AW), .CLR_WORDS(256)) dut (
        .mclk(mclk), .reset_n(reset_n),
        .wbd_cyc_i(cyc), .wbd_stb_i(stb), .wbd_we_i(we), .wbd_adr_i(adr),
        .wbd_sel_i(sel), .wbd_dat_i(dat_i), .wbd_dat_o(dat_o), .wbd_ack_o(ack),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_di_o(ram_di),
        .ram_do_i(ram_do), .clr_done_o(clr_done)
    );

    function automatic logic [31:0] fill(input int i);
`ifdef DFFRAM_CLR_EN
        return 32'hA5A5A5A5;
`else
        logic [7:0] b = i[7:0];
        return {b, ~b, 8'h3C, b ^ 8'h5A};
`endif
    endfunction

    // DFFRAM behaviour: registered Do on EN, byte-lane writes, Do holds while EN low
    always @(posedge mclk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill(i);
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+1:0] badr(input int w);
        logic [1:0] lo = 2'($urandom);
        return {w[AW-1:0], lo};
    endfunction

    task automatic ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[w] = (ref_mem[w] & ~m) | (d & m);
    endtask

    task automatic do_write(input int w, input logic [31:0] d, input logic [3:0] s);
        @(negedge mclk);
        cyc = 1; stb = 1; we = 1; adr = badr(w); sel = s; dat_i = d;
        #1;
        chk("wr_en", 32'(ram_en), 1);
        chk("wr_we", 32'(ram_we), 32'(s));
        chk("wr_a", 32'(ram_a), 32'(w));
        chk("wr_di", ram_di, d);
        chk("wr_ack_c0", 32'(ack), 0);
        @(negedge mclk);
        cyc = 0; stb = 0; we = 0;
        #1;
        chk("wr_ack_c1", 32'(ack), 1);
        chk("wr_en_c1", 32'(ram_en), 0);
        ref_write(w, d, s);
        @(negedge mclk);
        #1;
        chk("wr_ack_c2", 32'(ack), 0);
    endtask

    task automatic do_read(input int w);
        @(negedge mclk);
        cyc = 1; stb = 1; we = 0; adr = badr(w); sel = 4'($urandom); dat_i = $urandom;
        #1;
        chk("rd_en", 32'(ram_en), 1);
        chk("rd_we", 32'(ram_we), 0);
        chk("rd_a", 32'(ram_a), 32'(w));
        chk("rd_ack_c0", 32'(ack), 0);
        @(negedge mclk);
        #1;
        chk("rd_ack_c1", 32'(ack), 0);
        chk("rd_en_c1", 32'(ram_en), 0);
        @(negedge mclk);
        cyc = 0; stb = 0;
        #1;
        chk("rd_ack_c2", 32'(ack), 1);
        chk("rd_data", dat_o, ref_mem[w]);
        last_rd = ref_mem[w];
        @(negedge mclk);
        #1;
        chk("rd_ack_c3", 32'(ack), 0);
        chk("rd_hold", dat_o, last_rd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_dat"}, dat_o, 0);
        chk({tag, "_en"}, 32'(ram_en), 0);
        chk({tag, "_we"}, 32'(ram_we), 0);
        chk({tag, "_a"}, 32'(ram_a), 0);
        chk({tag, "_di"}, ram_di, 0);
`ifdef DFFRAM_CLR_EN
        chk({tag, "_done"}, 32'(clr_done), 0);
`else
        chk({tag, "_done"}, 32'(clr_done), 1);
`endif
    endtask

    task automatic wait_clear();
`ifdef DFFRAM_CLR_EN
        int n = -1;
        for (int c = 0; c < 300 && n < 0; c++) begin
            @(negedge mclk);
            #1;
            if (clr_done) n = c;
        end
        chk("clr_wait_bound", 32'(n >= 0), 1);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = fill(i);
        cyc = 1; stb = 1; we = 1; sel = 4'hF; dat_i = 32'h13572468; adr = badr(9);
        @(posedge mclk);
        @(negedge mclk);
        preload = 1'b0;
        @(negedge mclk);
        #1;
        chk_reset_outputs("rst");
`ifdef DFFRAM_CLR_EN
        begin
            int done_c = -1, ack_c = -1;
            cyc = 0; stb = 0; we = 0;
            @(negedge mclk);
            reset_n = 1;
            #1;
            chk("clr_c0_a", 32'(ram_a), 0);
            chk("clr_c0_en", 32'(ram_en), 1);
            chk("clr_c0_we", 32'(ram_we), 32'hF);
            chk("clr_c0_di", ram_di, 0);
            for (int c = 1; c <= 100; c++) @(negedge mclk);
            #1;
            chk("clr_c100_a", 32'(ram_a), 100);
            #2 reset_n = 0;
            #1;
            chk_reset_outputs("clr_rst");
            @(negedge mclk);
            reset_n = 1; cyc = 1; stb = 1; we = 0; adr = badr(255);
            #1;
            chk("clr_restart_a", 32'(ram_a), 0);
            chk("clr_restart_we", 32'(ram_we), 32'hF);
            for (int c = 1; c <= 300 && ack_c < 0; c++) begin
                @(negedge mclk);
                #1;
                if (clr_done && done_c < 0) done_c = c;
                if (ack) ack_c = c;
            end
            chk("clr_done_cycle", 32'(done_c), 256);
            chk("clr_rd_ack_cycle", 32'(ack_c), 258);
            chk("clr_rd_data", dat_o, 0);
            cyc = 0; stb = 0;
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            last_rd = '0;
        end
`else
        @(negedge mclk);
        reset_n = 1; adr = badr(7); dat_i = 32'h12345678; sel = 4'hF; we = 1; cyc = 1; stb = 1;
        #1;
        chk("rel_done", 32'(clr_done), 1);
        chk("rel_en", 32'(ram_en), 1);
        chk("rel_a", 32'(ram_a), 7);
        @(negedge mclk);
        cyc = 0; stb = 0; we = 0;
        #1;
        chk("rel_ack_c1", 32'(ack), 1);
        ref_write(7, 32'h12345678, 4'hF);
        do_read(7);
`endif
        do_write(4, 32'hDEADBEEF, 4'hF);
        do_read(4);
        do_write(5, 32'hFFFFFFFF, 4'hF);
        do_write(5, 32'h00000000, 4'b0101);
        do_read(5);
        chk("lane_merge", last_rd, 32'hFF00FF00);
        do_write(6, 32'hCAFEF00D, 4'h0);
        do_read(6);
        begin
            int k = 0, acks = 0, writes = 0;
            logic prev = 1'b0;
            @(negedge mclk);
            cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = badr(20); dat_i = 32'h0B0B0000;
            for (int c = 0; c < 24 && k < 4; c++) begin
                #1;
                if (ram_en && ram_we != 0) writes++;
                chk("b2b_gap", 32'(ack & prev), 0);
                prev = ack;
                if (ack) begin
                    acks++;
                    ref_write(20 + k, 32'h0B0B0000 + 32'(k), 4'hF);
                    k++;
                    adr = badr(20 + k); dat_i = 32'h0B0B0000 + 32'(k);
                    if (k == 4) begin cyc = 0; stb = 0; we = 0; end
                end
                @(negedge mclk);
            end
            chk("b2b_acks", 32'(acks), 4);
            chk("b2b_writes", 32'(writes), 4);
        end
        do_read(21);
        do_read(23);
        do_write(3, 32'h33333333, 4'hF);
        do_read(4);
        @(negedge mclk);
        cyc = 1; stb = 1; we = 0; adr = badr(3);
        @(negedge mclk);
        cyc = 0; stb = 0;
        #1;
        chk("drop_ack_c1", 32'(ack), 0);
        @(negedge mclk);
        #1;
        chk("drop_ack_c2", 32'(ack), 0);
        chk("drop_dat_hold", dat_o, last_rd);
        do_read(3);
        for (int t = 0; t < 40; t++) begin
            int w = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) do_write(w, $urandom, 4'($urandom));
            else do_read(w);
        end
        @(negedge mclk);
        cyc = 1; stb = 1; we = 0; adr = badr(5);
        @(negedge mclk);
        #2 reset_n = 0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge mclk);
        reset_n = 1; cyc = 0; stb = 0;
        wait_clear();
        do_write(9, 32'h600DF00D, 4'b1010);
        do_read(9);
        do_read(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
